// File: rtl/sync_fifo_ptr_ctrl_pkg.sv
// rtl/sync_fifo_ptr_ctrl_pkg.sv - depth derivation, threshold legality check and flag bundle type
package sync_fifo_ptr_ctrl_pkg;

    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
    } fifo_flags_t;

    localparam fifo_flags_t FIFO_FLAGS_RESET = '{
        full:         1'b0,
        almost_full:  1'b0,
        empty:        1'b1,
        almost_empty: 1'b1
    };

    function automatic int fifo_depth(input int addr_size);
        return 1 << addr_size;
    endfunction

    // A buffer equal to DEPTH would make almost_full true at reset, which the reset state contradicts.
    function automatic bit fifo_bufs_legal(input int addr_size, input int af_buf, input int ae_buf);
        return (af_buf >= 0) && (af_buf < fifo_depth(addr_size)) &&
               (ae_buf >= 0) && (ae_buf < fifo_depth(addr_size));
    endfunction

endpackage

// File: rtl/sync_fifo_ptr_ctrl_if.sv
// rtl/sync_fifo_ptr_ctrl_if.sv - request/accept, RAM address, flag and level bundle; SYNC_FIFO_ERR_EN adds overflow/underflow
interface sync_fifo_ptr_ctrl_if #(
    parameter int ADDR_SIZE = 4
);
    logic                 w_inc;
    logic                 r_inc;
    logic                 w_en;
    logic                 r_en;
    logic [ADDR_SIZE-1:0] w_addr;
    logic [ADDR_SIZE-1:0] r_addr;
    logic                 w_full;
    logic                 w_almost_full;
    logic                 r_empty;
    logic                 r_almost_empty;
    logic [ADDR_SIZE:0]   count;
`ifdef SYNC_FIFO_ERR_EN
    logic                 overflow;
    logic                 underflow;

    modport master (
        output w_inc, r_inc,
        input  w_en, r_en, w_addr, r_addr, w_full, w_almost_full,
        input  r_empty, r_almost_empty, count, overflow, underflow
    );

    modport slave (
        input  w_inc, r_inc,
        output w_en, r_en, w_addr, r_addr, w_full, w_almost_full,
        output r_empty, r_almost_empty, count, overflow, underflow
    );
`else
    modport master (
        output w_inc, r_inc,
        input  w_en, r_en, w_addr, r_addr, w_full, w_almost_full,
        input  r_empty, r_almost_empty, count
    );

    modport slave (
        input  w_inc, r_inc,
        output w_en, r_en, w_addr, r_addr, w_full, w_almost_full,
        output r_empty, r_almost_empty, count
    );
`endif
endinterface

// File: rtl/fifo_level_flags.sv
// rtl/fifo_level_flags.sv - maps a next fill level to the four next-state level flags
module fifo_level_flags
    import sync_fifo_ptr_ctrl_pkg::*;
#(
    parameter int ADDR_SIZE        = 4,
    parameter int ALMOST_FULL_BUF  = 1,
    parameter int ALMOST_EMPTY_BUF = 1
) (
    input  logic [ADDR_SIZE:0] count_next,
    output fifo_flags_t        flags_next
);

    localparam logic [ADDR_SIZE:0] DEPTH_LVL = (ADDR_SIZE+1)'(fifo_depth(ADDR_SIZE));
    localparam logic [ADDR_SIZE:0] AF_LVL    = (ADDR_SIZE+1)'(fifo_depth(ADDR_SIZE) - ALMOST_FULL_BUF);
    localparam logic [ADDR_SIZE:0] AE_LVL    = (ADDR_SIZE+1)'(ALMOST_EMPTY_BUF);

    always_comb begin
        flags_next              = '0;
        flags_next.full         = (count_next == DEPTH_LVL);
        flags_next.almost_full  = (count_next >= AF_LVL);
        flags_next.empty        = (count_next == '0);
        flags_next.almost_empty = (count_next <= AE_LVL);
    end

endmodule

// File: rtl/sync_fifo_ptr_ctrl.sv
// rtl/sync_fifo_ptr_ctrl.sv - single-clock FIFO pointer/flag controller; SYNC_FIFO_ERR_EN adds sticky overflow/underflow
module sync_fifo_ptr_ctrl
    import sync_fifo_ptr_ctrl_pkg::*;
#(
    parameter int ADDR_SIZE        = 4,
    parameter int ALMOST_FULL_BUF  = 1,
    parameter int ALMOST_EMPTY_BUF = 1
) (
    input  logic              clk,
    input  logic              reset,
    sync_fifo_ptr_ctrl_if.slave fifo
);

    if (!fifo_bufs_legal(ADDR_SIZE, ALMOST_FULL_BUF, ALMOST_EMPTY_BUF)) begin : g_bad_params
        $error("sync_fifo_ptr_ctrl: ALMOST_FULL_BUF and ALMOST_EMPTY_BUF must be in 0..DEPTH-1");
    end

    logic [ADDR_SIZE:0] w_bin;
    logic [ADDR_SIZE:0] r_bin;
    logic [ADDR_SIZE:0] w_bin_next;
    logic [ADDR_SIZE:0] r_bin_next;
    logic [ADDR_SIZE:0] count_q;
    logic [ADDR_SIZE:0] count_next;
    fifo_flags_t        flags_q;
    fifo_flags_t        flags_next;
    logic               w_accept;
    logic               r_accept;

    // Accepts depend only on registered flags, so w_inc never reaches r_en and vice versa.
    assign w_accept = fifo.w_inc & ~flags_q.full;
    assign r_accept = fifo.r_inc & ~flags_q.empty;

    assign w_bin_next = w_bin + (ADDR_SIZE+1)'(w_accept);
    assign r_bin_next = r_bin + (ADDR_SIZE+1)'(r_accept);
    // The extra MSB keeps full (difference DEPTH) apart from empty (difference 0).
    assign count_next = w_bin_next - r_bin_next;

    fifo_level_flags #(
        .ADDR_SIZE        (ADDR_SIZE),
        .ALMOST_FULL_BUF  (ALMOST_FULL_BUF),
        .ALMOST_EMPTY_BUF (ALMOST_EMPTY_BUF)
    ) u_level_flags (
        .count_next (count_next),
        .flags_next (flags_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            w_bin   <= '0;
            r_bin   <= '0;
            count_q <= '0;
            flags_q <= FIFO_FLAGS_RESET;
        end else begin
            w_bin   <= w_bin_next;
            r_bin   <= r_bin_next;
            count_q <= count_next;
            flags_q <= flags_next;
        end
    end

    assign fifo.w_en           = w_accept;
    assign fifo.r_en           = r_accept;
    assign fifo.w_addr         = w_bin[ADDR_SIZE-1:0];
    assign fifo.r_addr         = r_bin[ADDR_SIZE-1:0];
    assign fifo.w_full         = flags_q.full;
    assign fifo.w_almost_full  = flags_q.almost_full;
    assign fifo.r_empty        = flags_q.empty;
    assign fifo.r_almost_empty = flags_q.almost_empty;
    assign fifo.count          = count_q;

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky until reset so software can find a dropped request long after it happened.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q  | (fifo.w_inc & flags_q.full);
            underflow_q <= underflow_q | (fifo.r_inc & flags_q.empty);
        end
    end

    assign fifo.overflow  = overflow_q;
    assign fifo.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_ptr_ctrl.sv
// tb/tb_sync_fifo_ptr_ctrl.sv - directed self-checking bench, ADDR_SIZE=3, AF_BUF=2, AE_BUF=1
module tb_sync_fifo_ptr_ctrl;

    localparam int AW = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [7:0] mem [8];
    logic [7:0] sb_q [$];
    logic [7:0] tok = 8'h10;

    sync_fifo_ptr_ctrl_if #(.ADDR_SIZE(AW)) bus ();

    sync_fifo_ptr_ctrl #(
        .ADDR_SIZE        (AW),
        .ALMOST_FULL_BUF  (2),
        .ALMOST_EMPTY_BUF (1)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .fifo  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_cycle(input logic w, input logic r, output logic wen, output logic ren,
                            output logic [AW-1:0] wa, output logic [AW-1:0] ra);
        bus.w_inc = w;
        bus.r_inc = r;
        #1;
        wen = bus.w_en;
        ren = bus.r_en;
        wa  = bus.w_addr;
        ra  = bus.r_addr;
        @(posedge clk);
        #1;
        bus.w_inc = 1'b0;
        bus.r_inc = 1'b0;
    endtask

    task automatic test_reset();
        logic wen, ren;
        logic [AW-1:0] wa, ra;
        reset = 1'b1;
        do_cycle(1'b1, 1'b1, wen, ren, wa, ra);
        do_cycle(1'b1, 1'b0, wen, ren, wa, ra);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
            total++; if (bus.r_empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b expected 1", bus.r_empty); end
            total++; if (bus.r_almost_empty !== 1'b1) begin bad++; $display("FAIL reset_ae: got %b expected 1", bus.r_almost_empty); end
            total++; if (bus.w_full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b expected 0", bus.w_full); end
            total++; if (bus.w_almost_full !== 1'b0) begin bad++; $display("FAIL reset_af: got %b expected 0", bus.w_almost_full); end
            total++; if (bus.w_addr !== 3'd0) begin bad++; $display("FAIL reset_waddr: got %0d expected 0", bus.w_addr); end
            total++; if (bus.r_addr !== 3'd0) begin bad++; $display("FAIL reset_raddr: got %0d expected 0", bus.r_addr); end
`ifdef SYNC_FIFO_ERR_EN
            total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b expected 0", bus.overflow); end
`endif
            do_cycle(1'b0, 1'b0, wen, ren, wa, ra);
        end
    endtask

    task automatic test_fill();
        logic wen, ren;
        logic [AW-1:0] wa, ra;
        for (int k = 1; k <= 8; k++) begin
            do_cycle(1'b1, 1'b0, wen, ren, wa, ra);
            total++; if (wen !== 1'b1) begin bad++; $display("FAIL fill_wen[%0d]: got %b expected 1", k, wen); end
            total++; if (wa !== 3'(k-1)) begin bad++; $display("FAIL fill_waddr[%0d]: got %0d expected %0d", k, wa, k-1); end
            total++; if (bus.count !== 4'(k)) begin bad++; $display("FAIL fill_count[%0d]: got %0d expected %0d", k, bus.count, k); end
            total++; if (bus.r_empty !== 1'b0) begin bad++; $display("FAIL fill_empty[%0d]: got %b expected 0", k, bus.r_empty); end
            total++; if (bus.r_almost_empty !== logic'(k <= 1)) begin bad++; $display("FAIL fill_ae[%0d]: got %b expected %b", k, bus.r_almost_empty, k <= 1); end
            total++; if (bus.w_almost_full !== logic'(k >= 6)) begin bad++; $display("FAIL fill_af[%0d]: got %b expected %b", k, bus.w_almost_full, k >= 6); end
            total++; if (bus.w_full !== logic'(k == 8)) begin bad++; $display("FAIL fill_full[%0d]: got %b expected %b", k, bus.w_full, k == 8); end
        end
        do_cycle(1'b1, 1'b0, wen, ren, wa, ra);
        total++; if (wen !== 1'b0) begin bad++; $display("FAIL fill_ninth_wen: got %b expected 0", wen); end
        total++; if (wa !== 3'd0) begin bad++; $display("FAIL fill_ninth_waddr: got %0d expected 0", wa); end
        total++; if (bus.count !== 4'd8) begin bad++; $display("FAIL fill_ninth_count: got %0d expected 8", bus.count); end
        total++; if (bus.w_full !== 1'b1) begin bad++; $display("FAIL fill_ninth_full: got %b expected 1", bus.w_full); end
    endtask

    task automatic test_full_both();
        logic wen, ren;
        logic [AW-1:0] wa, ra;
        do_cycle(1'b1, 1'b1, wen, ren, wa, ra);
        total++; if (wen !== 1'b0) begin bad++; $display("FAIL fullboth_wen: got %b expected 0", wen); end
        total++; if (ren !== 1'b1) begin bad++; $display("FAIL fullboth_ren: got %b expected 1", ren); end
        total++; if (ra !== 3'd0) begin bad++; $display("FAIL fullboth_raddr: got %0d expected 0", ra); end
        total++; if (bus.count !== 4'd7) begin bad++; $display("FAIL fullboth_count: got %0d expected 7", bus.count); end
        total++; if (bus.w_full !== 1'b0) begin bad++; $display("FAIL fullboth_full: got %b expected 0", bus.w_full); end
        total++; if (bus.w_almost_full !== 1'b1) begin bad++; $display("FAIL fullboth_af: got %b expected 1", bus.w_almost_full); end
        do_cycle(1'b1, 1'b1, wen, ren, wa, ra);
        total++; if (wen !== 1'b1 || ren !== 1'b1) begin bad++; $display("FAIL both7_en: got %b%b expected 11", wen, ren); end
        total++; if (wa !== 3'd0) begin bad++; $display("FAIL both7_waddr: got %0d expected 0", wa); end
        total++; if (ra !== 3'd1) begin bad++; $display("FAIL both7_raddr: got %0d expected 1", ra); end
        total++; if (bus.count !== 4'd7) begin bad++; $display("FAIL both7_count: got %0d expected 7", bus.count); end
        for (int i = 0; i < 7; i++) begin
            do_cycle(1'b0, 1'b1, wen, ren, wa, ra);
            total++; if (ren !== 1'b1) begin bad++; $display("FAIL drain_ren[%0d]: got %b expected 1", i, ren); end
            total++; if (ra !== 3'(2+i)) begin bad++; $display("FAIL drain_raddr[%0d]: got %0d expected %0d", i, ra, (2+i)%8); end
            total++; if (bus.count !== 4'(6-i)) begin bad++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, bus.count, 6-i); end
            total++; if (bus.r_empty !== logic'(i == 6)) begin bad++; $display("FAIL drain_empty[%0d]: got %b expected %b", i, bus.r_empty, i == 6); end
        end
    endtask

    task automatic test_empty_both();
        logic wen, ren;
        logic [AW-1:0] wa, ra;
        do_cycle(1'b1, 1'b1, wen, ren, wa, ra);
        total++; if (wen !== 1'b1) begin bad++; $display("FAIL emptyboth_wen: got %b expected 1", wen); end
        total++; if (ren !== 1'b0) begin bad++; $display("FAIL emptyboth_ren: got %b expected 0", ren); end
        total++; if (wa !== 3'd1) begin bad++; $display("FAIL emptyboth_waddr: got %0d expected 1", wa); end
        total++; if (bus.count !== 4'd1) begin bad++; $display("FAIL emptyboth_count: got %0d expected 1", bus.count); end
        total++; if (bus.r_empty !== 1'b0) begin bad++; $display("FAIL emptyboth_empty: got %b expected 0", bus.r_empty); end
        total++; if (bus.r_almost_empty !== 1'b1) begin bad++; $display("FAIL emptyboth_ae: got %b expected 1", bus.r_almost_empty); end
        do_cycle(1'b0, 1'b1, wen, ren, wa, ra);
        total++; if (ren !== 1'b1 || ra !== 3'd1) begin bad++; $display("FAIL emptyread: got ren=%b ra=%0d expected ren=1 ra=1", ren, ra); end
        total++; if (bus.r_empty !== 1'b1) begin bad++; $display("FAIL emptyread_empty: got %b expected 1", bus.r_empty); end
        do_cycle(1'b0, 1'b1, wen, ren, wa, ra);
        total++; if (ren !== 1'b0) begin bad++; $display("FAIL underread_ren: got %b expected 0", ren); end
        total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL underread_count: got %0d expected 0", bus.count); end
`ifdef SYNC_FIFO_ERR_EN
        total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL underflow: got %b expected 1", bus.underflow); end
`endif
    endtask

    task automatic test_stream();
        logic wen, ren;
        logic [AW-1:0] wa, ra;
        logic [7:0] exp_d;
        int wp = 10;
        int rp = 10;
        for (int c = 0; c < 46; c++) begin
            logic w_req = (c < 43);
            logic r_req = (c >= 3);
            do_cycle(w_req, r_req, wen, ren, wa, ra);
            total++; if (wen !== w_req || ren !== r_req) begin bad++; $display("FAIL stream_en[%0d]: got %b%b expected %b%b", c, wen, ren, w_req, r_req); end
            if (r_req) begin
                total++; if (ra !== 3'(rp)) begin bad++; $display("FAIL stream_raddr[%0d]: got %0d expected %0d", c, ra, rp % 8); end
                exp_d = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
                total++; if (mem[ra] !== exp_d) begin bad++; $display("FAIL stream_data[%0d]: got %h expected %h", c, mem[ra], exp_d); end
                rp++;
            end
            if (w_req) begin
                total++; if (wa !== 3'(wp)) begin bad++; $display("FAIL stream_waddr[%0d]: got %0d expected %0d", c, wa, wp % 8); end
                mem[wa] = tok;
                sb_q.push_back(tok);
                tok++;
                wp++;
            end
            if (c >= 2 && c < 43) begin
                total++; if (bus.count !== 4'd3) begin bad++; $display("FAIL stream_count[%0d]: got %0d expected 3", c, bus.count); end
                total++; if ({bus.w_full, bus.w_almost_full, bus.r_empty, bus.r_almost_empty} !== 4'b0000) begin
                    bad++; $display("FAIL stream_flags[%0d]: got %b expected 0000", c,
                                    {bus.w_full, bus.w_almost_full, bus.r_empty, bus.r_almost_empty});
                end
            end
        end
        total++; if (bus.count !== 4'd0 || bus.r_empty !== 1'b1) begin bad++; $display("FAIL stream_end: got count=%0d empty=%b expected 0/1", bus.count, bus.r_empty); end
    endtask

    task automatic test_reset_mid();
        logic wen, ren;
        logic [AW-1:0] wa, ra;
        for (int k = 0; k < 9; k++) do_cycle(1'b1, 1'b0, wen, ren, wa, ra);
`ifdef SYNC_FIFO_ERR_EN
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL overflow_set: got %b expected 1", bus.overflow); end
`endif
        for (int k = 0; k < 3; k++) do_cycle(1'b0, 1'b1, wen, ren, wa, ra);
        total++; if (bus.count !== 4'd5) begin bad++; $display("FAIL premid_count: got %0d expected 5", bus.count); end
        reset = 1'b1;
        do_cycle(1'b1, 1'b0, wen, ren, wa, ra);
        reset = 1'b0;
        total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL mid_count: got %0d expected 0", bus.count); end
        total++; if (bus.r_empty !== 1'b1 || bus.r_almost_empty !== 1'b1) begin bad++; $display("FAIL mid_empty: got %b%b expected 11", bus.r_empty, bus.r_almost_empty); end
        total++; if (bus.w_full !== 1'b0 || bus.w_almost_full !== 1'b0) begin bad++; $display("FAIL mid_full: got %b%b expected 00", bus.w_full, bus.w_almost_full); end
        total++; if (bus.w_addr !== 3'd0 || bus.r_addr !== 3'd0) begin bad++; $display("FAIL mid_addr: got %0d/%0d expected 0/0", bus.w_addr, bus.r_addr); end
`ifdef SYNC_FIFO_ERR_EN
        total++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin bad++; $display("FAIL mid_err: got %b%b expected 00", bus.overflow, bus.underflow); end
`endif
        do_cycle(1'b1, 1'b0, wen, ren, wa, ra);
        total++; if (wa !== 3'd0 || bus.count !== 4'd1) begin bad++; $display("FAIL post_reset_write: got wa=%0d count=%0d expected 0/1", wa, bus.count); end
    endtask

    initial begin
        bus.w_inc = 1'b0;
        bus.r_inc = 1'b0;
        test_reset();
        test_fill();
        test_full_both();
        test_empty_both();
        test_stream();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
